// File: rtl/sd_spi_master.sv
`timescale 1ns/1ps
// sd_spi_master
//   Byte-level SPI mode-0 initiator for an SD-card responder. Each accepted byte
//   is shifted out MSB first on spi_mosi, while spi_miso is captured on every SCK
//   rising edge. The received byte is presented with a one-cycle rx_valid pulse.
//
// Parameters
//   SLOW_DIV  clk_sys cycles per SCK half-period at init speed (>= 1)
//   FAST_DIV  clk_sys cycles per SCK half-period at data speed (1..SLOW_DIV)
//
// Ports
//   clk_sys, hard_reset_n       clock, asynchronous active-low reset
//   tx_data/tx_valid/tx_ready   byte request handshake (accept = valid & ready)
//   fast                        speed select, sampled at accept
//   cs_assert                   1 drives spi_ss low, sampled only while idle
//   rx_data/rx_valid            received byte and its one-cycle strobe
//   busy                        transfer in progress (= ~tx_ready)
//   spi_sck/spi_mosi/spi_miso/spi_ss   SPI pins (CPOL=0, CPHA=0)
module sd_spi_master #(
  parameter int SLOW_DIV = 64,
  parameter int FAST_DIV = 2
) (
  input  logic       clk_sys,
  input  logic       hard_reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       fast,
  input  logic       cs_assert,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_ss
);

  localparam int CW = $clog2(SLOW_DIV + 1);
  localparam logic [CW-1:0] SLOW_LD = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0] FAST_LD = CW'(FAST_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ld_q, ld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          ss_q, ss_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;

  always_ff @(posedge clk_sys or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_q    <= IDLE;
      ld_q       <= SLOW_LD;
      cnt_q      <= '0;
      bit_q      <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b1;
      ss_q       <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_q       <= ld_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      ss_q       <= ss_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Shift registers carry pure data; their contents are always reloaded or
  // fully shifted before use, so they need no reset.
  always_ff @(posedge clk_sys) begin
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  always_comb begin
    state_d    = state_q;
    ld_d       = ld_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    ss_d       = ss_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    case (state_q)
      IDLE: begin
        // SS follows cs_assert only between bytes, including the accept edge,
        // so it is frozen whenever SCK can toggle.
        ss_d = ~cs_assert;
        if (tx_valid) begin
          state_d = LOW;
          ld_d    = fast ? FAST_LD : SLOW_LD;
          cnt_d   = fast ? FAST_LD : SLOW_LD;
          tx_sh_d = tx_data;
          bit_d   = 3'd0;
          mosi_d  = tx_data[7];
          sck_d   = 1'b0;
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          state_d = HIGH;
          cnt_d   = ld_q;
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], spi_miso};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          cnt_d = ld_q;
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d    = IDLE;
            mosi_d     = 1'b1;
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
          end else begin
            state_d = LOW;
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
            mosi_d  = tx_sh_q[6];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = ~tx_ready;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_ss   = ss_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_sd_spi_master.sv
`timescale 1ns/1ps
module tb_sd_spi_master;

  logic       clk_sys = 1'b0;
  logic       hard_reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       fast;
  logic       cs_assert;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_ss;
  logic [1:0] miso_mode;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  // 0: tied low, 1: tied high, 2: looped to mosi, 3: inverted mosi
  assign spi_miso = (miso_mode == 2'd0) ? 1'b0 :
                    (miso_mode == 2'd1) ? 1'b1 :
                    (miso_mode == 2'd2) ? spi_mosi : ~spi_mosi;

  sd_spi_master #(.SLOW_DIV(64), .FAST_DIV(2)) dut (
    .clk_sys(clk_sys), .hard_reset_n(hard_reset_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fast(fast), .cs_assert(cs_assert),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss(spi_ss)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Issues one byte and watches it until rx_valid (cycle 1 = first cycle after
  // the accept edge). Returns with the bench sitting in the rx_valid cycle.
  task automatic xfer(input logic [7:0] d, input logic f, input logic cs,
                      input int toggle, input int spur,
                      output int lat, output logic [7:0] rx, output int nhigh,
                      output int minrun, output int maxrun,
                      output logic [7:0] mbits, output logic ss0, output int ss_chg);
    int   run;
    logic prev;
    tx_data   = d;
    fast      = f;
    cs_assert = cs;
    tx_valid  = 1'b1;
    for (int w = 0; w < 2000 && tx_ready !== 1'b1; w++) tick();
    tick();
    tx_valid = 1'b0;
    lat = -1; rx = 8'hxx; nhigh = 0; minrun = 1 << 30; maxrun = 0;
    mbits = 8'h00; ss0 = spi_ss; ss_chg = 0; run = 0; prev = 1'b0;
    for (int cyc = 1; cyc < 2000; cyc++) begin
      if (spi_ss !== ss0) ss_chg++;
      if (spi_sck === 1'b1) begin
        if (!prev) begin
          nhigh++;
          mbits = {mbits[6:0], spi_mosi};
          run = 0;
        end
        run++;
      end else if (prev) begin
        if (run < minrun) minrun = run;
        if (run > maxrun) maxrun = run;
      end
      prev = spi_sck;
      if (rx_valid === 1'b1) begin
        lat = cyc;
        rx  = rx_data;
        break;
      end
      if (toggle != 0 && cyc == 5) begin
        fast      = ~fast;
        cs_assert = ~cs_assert;
      end
      if (spur != 0 && cyc == 3) begin
        tx_valid = 1'b1;
        tx_data  = 8'h00;
      end
      if (spur != 0 && cyc == 10) tx_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    total++; if (spi_sck !== 1'b0) begin bad++; $display("FAIL rst_sck got=%b exp=0", spi_sck); end
    total++; if (spi_mosi !== 1'b1) begin bad++; $display("FAIL rst_mosi got=%b exp=1", spi_mosi); end
    total++; if (spi_ss !== 1'b1) begin bad++; $display("FAIL rst_ss got=%b exp=1", spi_ss); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
  endtask

  task automatic test_fast_loopback();
    int lat, nh, mn, mx, sc;
    logic [7:0] rx, mb;
    logic s0;
    miso_mode = 2'd2;
    xfer(8'hA5, 1'b1, 1'b1, 0, 0, lat, rx, nh, mn, mx, mb, s0, sc);
    total++; if (lat != 33) begin bad++; $display("FAIL fast_latency got=%0d exp=33", lat); end
    total++; if (rx !== 8'hA5) begin bad++; $display("FAIL fast_rx got=%h exp=a5", rx); end
    total++; if (mb !== 8'hA5) begin bad++; $display("FAIL fast_mosi_bits got=%h exp=a5", mb); end
    total++; if (nh != 8) begin bad++; $display("FAIL fast_sck_highs got=%0d exp=8", nh); end
    total++; if (mn != 2 || mx != 2) begin bad++; $display("FAIL fast_sck_width got=%0d..%0d exp=2..2", mn, mx); end
    total++; if (s0 !== 1'b0 || sc != 0) begin bad++; $display("FAIL fast_ss_low got=%b changes=%0d exp=0 changes=0", s0, sc); end
    total++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL fast_ready_at_rxv got=%b/%b exp=1/0", tx_ready, busy); end
    total++; if (spi_mosi !== 1'b1 || spi_sck !== 1'b0) begin bad++; $display("FAIL fast_idle_pins got=%b/%b exp=1/0", spi_mosi, spi_sck); end
    tick();
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL fast_rxv_pulse got=%b exp=0", rx_valid); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL fast_rx_hold got=%h exp=a5", rx_data); end
  endtask

  task automatic test_slow();
    int lat, nh, mn, mx, sc;
    logic [7:0] rx, mb;
    logic s0;
    miso_mode = 2'd1;
    xfer(8'h40, 1'b0, 1'b1, 0, 0, lat, rx, nh, mn, mx, mb, s0, sc);
    total++; if (lat != 1025) begin bad++; $display("FAIL slow_latency got=%0d exp=1025", lat); end
    total++; if (rx !== 8'hFF) begin bad++; $display("FAIL slow_rx got=%h exp=ff", rx); end
    total++; if (mb !== 8'h40) begin bad++; $display("FAIL slow_mosi_bits got=%h exp=40", mb); end
    total++; if (nh != 8 || mn != 64 || mx != 64) begin bad++; $display("FAIL slow_sck got=%0d highs %0d..%0d exp=8 highs 64..64", nh, mn, mx); end
    tick();
  endtask

  task automatic test_busy_ignored();
    int lat, nh, mn, mx, sc;
    logic [7:0] rx, mb;
    logic s0;
    miso_mode = 2'd2;
    xfer(8'h3C, 1'b1, 1'b1, 0, 1, lat, rx, nh, mn, mx, mb, s0, sc);
    total++; if (lat != 33 || rx !== 8'h3C) begin bad++; $display("FAIL busy_ignore_xfer got=%0d/%h exp=33/3c", lat, rx); end
    tick();
    total++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL busy_ignore_noqueue got=%b/%b exp=1/0", tx_ready, busy); end
  endtask

  task automatic test_toggle_mid_byte();
    int lat, nh, mn, mx, sc;
    logic [7:0] rx, mb;
    logic s0;
    miso_mode = 2'd2;
    xfer(8'h5A, 1'b1, 1'b1, 1, 0, lat, rx, nh, mn, mx, mb, s0, sc);
    total++; if (lat != 33 || rx !== 8'h5A) begin bad++; $display("FAIL toggle_latency got=%0d/%h exp=33/5a", lat, rx); end
    total++; if (s0 !== 1'b0 || sc != 0) begin bad++; $display("FAIL toggle_ss_frozen got=%b changes=%0d exp=0 changes=0", s0, sc); end
    total++; if (mn != 2 || mx != 2) begin bad++; $display("FAIL toggle_sck_width got=%0d..%0d exp=2..2", mn, mx); end
    xfer(8'h81, fast, cs_assert, 0, 0, lat, rx, nh, mn, mx, mb, s0, sc);
    total++; if (lat != 1025 || rx !== 8'h81) begin bad++; $display("FAIL toggle_next_slow got=%0d/%h exp=1025/81", lat, rx); end
    total++; if (s0 !== 1'b1 || sc != 0) begin bad++; $display("FAIL toggle_next_ss got=%b changes=%0d exp=1 changes=0", s0, sc); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    miso_mode = 2'd3;
    fast = 1'b1; cs_assert = 1'b1;
    tx_data = 8'h12; tx_valid = 1'b1;
    for (int w = 0; w < 2000 && tx_ready !== 1'b1; w++) tick();
    tick();
    tx_data = 8'h34;
    lat1 = -1;
    for (int cyc = 1; cyc < 2000; cyc++) begin
      if (rx_valid === 1'b1) begin lat1 = cyc; break; end
      tick();
    end
    total++; if (lat1 != 33 || rx_data !== 8'hED) begin bad++; $display("FAIL b2b_first got=%0d/%h exp=33/ed", lat1, rx_data); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_at_rxv got=%b exp=1", tx_ready); end
    tick();
    tx_valid = 1'b0;
    total++; if (busy !== 1'b1 || spi_mosi !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b/%b exp=1/0", busy, spi_mosi); end
    lat2 = -1;
    for (int cyc = 1; cyc < 2000; cyc++) begin
      if (rx_valid === 1'b1) begin lat2 = cyc; break; end
      tick();
    end
    total++; if (lat2 != 33 || rx_data !== 8'hCB) begin bad++; $display("FAIL b2b_second got=%0d/%h exp=33/cb", lat2, rx_data); end
    tick();
  endtask

  task automatic test_async_reset();
    int seen;
    miso_mode = 2'd1;
    fast = 1'b0; cs_assert = 1'b1;
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (99) tick();
    total++; if (spi_sck !== 1'b1 || spi_ss !== 1'b0) begin bad++; $display("FAIL areset_pre got=%b/%b exp=1/0", spi_sck, spi_ss); end
    #2 hard_reset_n = 1'b0;
    #1;
    total++; if (spi_sck !== 1'b0 || spi_mosi !== 1'b1 || spi_ss !== 1'b1) begin bad++; $display("FAIL areset_pins got=%b%b%b exp=011", spi_sck, spi_mosi, spi_ss); end
    total++; if (tx_ready !== 1'b1 || busy !== 1'b0 || rx_data !== 8'h00) begin bad++; $display("FAIL areset_state got=%b/%b/%h exp=1/0/00", tx_ready, busy, rx_data); end
    tick(); tick();
    hard_reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 1100; i++) begin
      if (rx_valid === 1'b1) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL areset_no_rxv got=%0d exp=0", seen); end
  endtask

  initial begin
    hard_reset_n = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0; fast = 1'b0; cs_assert = 1'b0; miso_mode = 2'd0;
    #2 hard_reset_n = 1'b0;
    repeat (3) tick();
    hard_reset_n = 1'b1;
    tick();
    test_reset();
    test_fast_loopback();
    test_slow();
    test_busy_ignored();
    test_toggle_mid_byte();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
